// File: rtl/ctr_sched_pkg.sv
// Shared types and time-pulse constants for the counter-cycle scheduler.
package ctr_sched_pkg;

    typedef enum logic {
        ST_INST = 1'b0,
        ST_CTR  = 1'b1
    } state_t;

    typedef enum logic {
        DIR_PLUS  = 1'b0,
        DIR_MINUS = 1'b1
    } dir_t;

    localparam int TP_T07 = 6;
    localparam int TP_T12 = 11;

endpackage

// File: rtl/ctr_priority_enc.sv
// Lowest-index-first priority encoder; bit 0 has the highest priority.
module ctr_priority_enc #(
    parameter int N  = 20,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/counter_cycle_scheduler.sv
// Interleaves PINC/MINC counter cycles with instruction cycles on the T12 boundary.
// Optional overflow chaining into the next cell is built when CTR_OVF_CHAIN_EN is defined.
module counter_cycle_scheduler
    import ctr_sched_pkg::*;
#(
    parameter int NCELL     = 20,
    parameter int MAX_BURST = 3,
    parameter int IDX_W     = $clog2(NCELL)
`ifdef CTR_OVF_CHAIN_EN
    ,
    parameter logic [NCELL-1:0] CHAIN_MASK = NCELL'(1)
`endif
) (
    input  logic             CLOCK,
    input  logic             SIM_RST,
    input  logic [11:0]      TP,
    input  logic             GOJAM,
    input  logic             STOP,
    input  logic [NCELL-1:0] PINC_REQ,
    input  logic [NCELL-1:0] MINC_REQ,
    input  logic             OVF,
    input  logic             UNF,
    output logic             CTR_CYCLE,
    output logic [IDX_W-1:0] CTR_IDX,
    output logic             CTR_DIR,
    output logic             CTR_OVF,
    output logic             CTR_PEND,
    output logic             BURST_YIELD
);

    localparam int BW = $clog2(MAX_BURST + 1);

    state_t           state_q, state_n;
    dir_t             dir_q, dir_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [BW-1:0]    burst_q, burst_n;
    logic             yield_q, yield_n;
    logic             ovf_q, ovf_n;
    logic [NCELL-1:0] pp_q, pp_n;
    logic [NCELL-1:0] mp_q, mp_n;
    logic [1:0]       tp_q;

    logic             tp_ok;
    logic             t07_ev;
    logic             t12_ev;
    logic             end_ctr;
    logic             ovf_hit;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [NCELL-1:0] pinc_eff;

    // Events are taken only from a clean one-hot pulse level; an idle timer produces none.
    assign tp_ok   = (TP != 12'd0) && ((TP & (TP - 12'd1)) == 12'd0);
    assign t07_ev  = tp_ok && TP[TP_T07] && !tp_q[0];
    assign t12_ev  = tp_ok && TP[TP_T12] && !tp_q[1];
    assign end_ctr = t12_ev && (state_q == ST_CTR);
    assign ovf_hit = t07_ev && (state_q == ST_CTR) &&
                     ((dir_q == DIR_MINUS) ? UNF : OVF);

`ifdef CTR_OVF_CHAIN_EN
    logic [NCELL-1:0] chain_req;

    always_comb begin
        chain_req = '0;
        for (int i = 0; i < NCELL - 1; i++) begin
            if (ovf_hit && (dir_q == DIR_PLUS) && CHAIN_MASK[i] && (idx_q == IDX_W'(i))) begin
                chain_req[i+1] = 1'b1;
            end
        end
    end

    assign pinc_eff = PINC_REQ | chain_req;
`else
    assign pinc_eff = PINC_REQ;
`endif

    // Requests cancel against the opposite pending bit; the served bit survives only a same-direction request.
    always_comb begin
        pp_n = pp_q;
        mp_n = mp_q;
        for (int i = 0; i < NCELL; i++) begin
            if (pinc_eff[i] && !MINC_REQ[i]) begin
                if (mp_q[i]) mp_n[i] = 1'b0;
                else         pp_n[i] = 1'b1;
            end else if (MINC_REQ[i] && !pinc_eff[i]) begin
                if (pp_q[i]) pp_n[i] = 1'b0;
                else         mp_n[i] = 1'b1;
            end
        end
        if (end_ctr) begin
            if (dir_q == DIR_PLUS) begin
                if (!(pinc_eff[idx_q] && !MINC_REQ[idx_q])) pp_n[idx_q] = 1'b0;
            end else begin
                if (!(MINC_REQ[idx_q] && !pinc_eff[idx_q])) mp_n[idx_q] = 1'b0;
            end
        end
        if (GOJAM) begin
            pp_n = '0;
            mp_n = '0;
        end
    end

    // Arbitrate on the post-update pending set so a cancelled or just-served bit is never picked.
    ctr_priority_enc #(
        .N  (NCELL),
        .IW (IDX_W)
    ) u_prio (
        .req   (pp_n | mp_n),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_comb begin
        state_n = state_q;
        burst_n = burst_q;
        idx_n   = idx_q;
        dir_n   = dir_q;
        yield_n = yield_q;
        ovf_n   = ovf_hit;
        if (t12_ev) begin
            if (win_valid && !STOP && (burst_q < BW'(MAX_BURST))) begin
                state_n = ST_CTR;
                burst_n = burst_q + 1'b1;
                idx_n   = win_idx;
                dir_n   = dir_t'(mp_n[win_idx]);
                yield_n = 1'b0;
            end else begin
                state_n = ST_INST;
                burst_n = '0;
                yield_n = win_valid && !STOP && (burst_q >= BW'(MAX_BURST));
            end
        end
        if (GOJAM) begin
            state_n = ST_INST;
            burst_n = '0;
            yield_n = 1'b0;
            ovf_n   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (SIM_RST) begin
            state_q <= ST_INST;
            dir_q   <= DIR_PLUS;
            idx_q   <= '0;
            burst_q <= '0;
            yield_q <= 1'b0;
            ovf_q   <= 1'b0;
            pp_q    <= '0;
            mp_q    <= '0;
            tp_q    <= '0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            idx_q   <= idx_n;
            burst_q <= burst_n;
            yield_q <= yield_n;
            ovf_q   <= ovf_n;
            pp_q    <= pp_n;
            mp_q    <= mp_n;
            tp_q    <= {TP[TP_T12], TP[TP_T07]};
        end
    end

    assign CTR_CYCLE   = (state_q == ST_CTR);
    assign CTR_IDX     = idx_q;
    assign CTR_DIR     = dir_q;
    assign CTR_OVF     = ovf_q;
    assign CTR_PEND    = |(pp_q | mp_q);
    assign BURST_YIELD = yield_q;

endmodule

// File: tb/tb_counter_cycle_scheduler.sv
// Directed bench for counter_cycle_scheduler: table of per-MCT vectors plus hand sequences
// for overflow, GOJAM, STOP and idle-timer corners.
module tb_counter_cycle_scheduler;

    localparam int NCELL = 20;
    localparam int IDX_W = 5;
    localparam int NVEC  = 20;

    logic             clock;
    logic             simRst;
    logic [11:0]      tp;
    logic             gojam;
    logic             stop;
    logic [NCELL-1:0] pincReq;
    logic [NCELL-1:0] mincReq;
    logic             ovf;
    logic             unf;
    logic             ctrCycle;
    logic [IDX_W-1:0] ctrIdx;
    logic             ctrDir;
    logic             ctrOvf;
    logic             ctrPend;
    logic             burstYield;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [NCELL-1:0] p1;
        logic [NCELL-1:0] m1;
        logic [NCELL-1:0] p2;
        logic [NCELL-1:0] m2;
        logic             stopIn;
        logic             expCycle;
        logic [IDX_W-1:0] expIdx;
        logic             expDir;
        logic             expPend;
        logic             expYield;
    } vec_t;

    vec_t vecs [NVEC];

    counter_cycle_scheduler dut (
        .CLOCK       (clock),
        .SIM_RST     (simRst),
        .TP          (tp),
        .GOJAM       (gojam),
        .STOP        (stop),
        .PINC_REQ    (pincReq),
        .MINC_REQ    (mincReq),
        .OVF         (ovf),
        .UNF         (unf),
        .CTR_CYCLE   (ctrCycle),
        .CTR_IDX     (ctrIdx),
        .CTR_DIR     (ctrDir),
        .CTR_OVF     (ctrOvf),
        .CTR_PEND    (ctrPend),
        .BURST_YIELD (burstYield)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic expCycle, input logic [IDX_W-1:0] expIdx,
                              input logic expDir, input logic expPend, input logic expYield);
        checkOutput({tag, ".cycle"}, 32'(ctrCycle), 32'(expCycle));
        if (expCycle) begin
            checkOutput({tag, ".idx"}, 32'(ctrIdx), 32'(expIdx));
            checkOutput({tag, ".dir"}, 32'(ctrDir), 32'(expDir));
        end
        checkOutput({tag, ".pend"}, 32'(ctrPend), 32'(expPend));
        checkOutput({tag, ".yield"}, 32'(burstYield), 32'(expYield));
    endtask

    // Two request clocks while the timer sits between events, STOP held as given.
    task automatic applyStimulus(input logic [NCELL-1:0] p1, input logic [NCELL-1:0] m1,
                                 input logic [NCELL-1:0] p2, input logic [NCELL-1:0] m2,
                                 input logic stopIn);
        stop    = stopIn;
        pincReq = p1;
        mincReq = m1;
        tick();
        pincReq = p2;
        mincReq = m2;
        tick();
        pincReq = '0;
        mincReq = '0;
    endtask

    // Each time pulse lasts two clocks; OVF/UNF are presented only during T07.
    task automatic runPulses(input int first, input int last, input logic ovfIn, input logic unfIn,
                             output int ovfSeen);
        ovfSeen = 0;
        for (int k = first; k <= last; k++) begin
            tp    = '0;
            tp[k] = 1'b1;
            ovf   = (k == 6) ? ovfIn : 1'b0;
            unf   = (k == 6) ? unfIn : 1'b0;
            for (int c = 0; c < 2; c++) begin
                tick();
                if (ctrOvf) ovfSeen++;
            end
        end
        ovf = 1'b0;
        unf = 1'b0;
    endtask

    task automatic runMct(input logic ovfIn, input logic unfIn, output int ovfSeen);
        runPulses(0, 11, ovfIn, unfIn, ovfSeen);
    endtask

    initial begin
        int ovfSeen;

        vecs[0]  = '{20'h00020, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{20'h00080, 20'h00008, 20'h0, 20'h0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{20'h00004, 20'h0, 20'h0, 20'h00004, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{20'h0001F, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{20'h00010, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{20'h00140, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{20'h0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};

        simRst  = 1'b1;
        tp      = '0;
        gojam   = 1'b0;
        stop    = 1'b0;
        pincReq = '0;
        mincReq = '0;
        ovf     = 1'b0;
        unf     = 1'b0;
        repeat (3) tick();
        simRst = 1'b0;
        checkState("reset", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.idx", 32'(ctrIdx), 32'd0);
        checkOutput("reset.ovf", 32'(ctrOvf), 32'd0);

        $display("[TB] table vectors");
        for (int v = 0; v < NVEC; v++) begin
            applyStimulus(vecs[v].p1, vecs[v].m1, vecs[v].p2, vecs[v].m2, vecs[v].stopIn);
            runMct(1'b0, 1'b0, ovfSeen);
            checkState($sformatf("vec%0d", v), vecs[v].expCycle, vecs[v].expIdx,
                       vecs[v].expDir, vecs[v].expPend, vecs[v].expYield);
        end
        stop = 1'b0;

        $display("[TB] overflow on plus cycle of cell 0");
        applyStimulus(20'h00001, 20'h0, 20'h0, 20'h0, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("ovf.start", 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        runMct(1'b1, 1'b0, ovfSeen);
        checkOutput("ovf.pulse", 32'(ovfSeen), 32'd1);
`ifdef CTR_OVF_CHAIN_EN
        checkState("ovf.chain", 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
`endif
        checkState("ovf.done", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] overflow input ignored on minus cycle, underflow honoured");
        applyStimulus(20'h0, 20'h00001, 20'h0, 20'h0, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("unf.start", 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        runMct(1'b1, 1'b0, ovfSeen);
        checkOutput("unf.noovf", 32'(ovfSeen), 32'd0);
        applyStimulus(20'h0, 20'h00001, 20'h0, 20'h0, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        runMct(1'b0, 1'b1, ovfSeen);
        checkOutput("unf.pulse", 32'(ovfSeen), 32'd1);

        $display("[TB] GOJAM mid counter cycle");
        applyStimulus(20'h00202, 20'h0, 20'h0, 20'h0, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("gojam.before", 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
        runPulses(0, 2, 1'b0, 1'b0, ovfSeen);
        tp      = 12'h008;
        gojam   = 1'b1;
        pincReq = 20'h00020;
        tick();
        gojam   = 1'b0;
        pincReq = '0;
        checkState("gojam.now", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        runPulses(3, 11, 1'b0, 1'b0, ovfSeen);
        checkState("gojam.after", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] STOP holds off new cycles");
        applyStimulus(20'h00010, 20'h0, 20'h0, 20'h0, 1'b1);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("stop.1", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("stop.2", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        stop = 1'b0;
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("stop.release", 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("stop.done", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] idle timer holds state");
        applyStimulus(20'h00400, 20'h0, 20'h0, 20'h0, 1'b0);
        tp = '0;
        repeat (6) tick();
        checkState("idle.hold", 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("idle.serve", 1'b1, 5'd10, 1'b0, 1'b1, 1'b0);
        runMct(1'b0, 1'b0, ovfSeen);
        checkState("idle.done", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/counter_cycle_scheduler.md
Name: counter_cycle_scheduler

Overview:
Schedules counter-increment memory cycles (PINC/MINC) between ordinary instruction memory cycles, using the twelve time pulses T01–T12 generated by the timer. Per-cell requests are latched; a fixed-priority arbiter selects one cell at each cycle boundary. The block drives the counter-cycle indication, cell index and direction that sequence the shared write/overflow datapath. It honours GOJAM (abort and clear) and STOP (no new cycles).

Parameters:
NCELL, 20, number of counter cells (requesters); cell 0 has the highest priority.
MAX_BURST, 3, maximum number of back-to-back counter cycles before one instruction cycle is forced.
IDX_W, $clog2(NCELL), width of the cell index.

Ports:
CLOCK  input  1  system clock
SIM_RST  input  1  synchronous reset, active-high
TP  input  12  time-pulse levels, one-hot; bit k = T(k+1); each pulse is level-held for several CLOCKs
GOJAM  input  1  restart; clears all scheduler state
STOP  input  1  inhibits the start of new counter cycles
PINC_REQ  input  NCELL  per-cell plus-increment request, one-CLOCK pulse
MINC_REQ  input  NCELL  per-cell minus-increment request, one-CLOCK pulse
OVF  input  1  overflow from the write-bus check, valid while T07 is high
UNF  input  1  underflow from the write-bus check, valid while T07 is high
CTR_CYCLE  output  1  current memory cycle is a counter cycle
CTR_IDX  output  IDX_W  cell being served; stable for the whole counter cycle
CTR_DIR  output  1  0 = plus, 1 = minus
CTR_OVF  output  1  one-CLOCK pulse: served cell overflowed or underflowed
CTR_PEND  output  1  OR of all pending bits
BURST_YIELD  output  1  high for the instruction cycle forced by the burst limit

Behaviour:
- Reset (SIM_RST=1 at a CLOCK edge): all pending bits, state, burst count and outputs = 0. SIM_RST has precedence over GOJAM.
- Edge detect: registered copy of TP. The T12 event is the first CLOCK where TP[11]=1 and the registered bit = 0; the T07 event is defined the same way on TP[6]. Each event fires once per pulse.
- Pending: two bits per cell, pp[i] and mp[i].
  - PINC_REQ[i] sets pp[i] unless mp[i] is set; in that case it clears mp[i] (net-zero cancel).
  - MINC_REQ[i] is symmetric.
  - PINC and MINC on the same cell in the same CLOCK: no change.
  - pp and mp are never both 1.
- States: INST (instruction cycle) and CTR (counter cycle). Transitions are evaluated only on the T12 event.
  - Start CTR when CTR_PEND=1, STOP=0 and burst < MAX_BURST.
  - Winner = lowest i with pp|mp set. Latch CTR_IDX = i and CTR_DIR = mp[i]. burst += 1.
  - Otherwise go to INST. If the reason was burst = MAX_BURST, assert BURST_YIELD for that cycle.
  - burst resets to 0 whenever INST is entered.
- CTR_CYCLE=1 from the CLOCK after the T12 event that starts CTR until the CLOCK after the next T12 event.
- T07 event in CTR: CTR_OVF pulses one CLOCK if (DIR=0 and OVF) or (DIR=1 and UNF).
- T12 event ending CTR: clear the served pending bit.
  - A request for the same cell in the same CLOCK wins: a same-direction request leaves the bit set; an opposite-direction request leaves the bit clear (cancel).
  - A new winner is selected in the same evaluation, so back-to-back cycles have no gap.
- STOP asserted mid-CTR: the current cycle completes; no new CTR starts. Requests keep accumulating.
- GOJAM=1 at any CLOCK:
  - clear pending, burst, CTR_OVF and BURST_YIELD;
  - force INST; CTR_CYCLE=0 on the next CLOCK;
  - requests arriving in the same CLOCK are discarded.
- TP with no bit set (stopped timer): no events; state holds.

Optional Feature:
CTR_OVF_CHAIN_EN
- With the macro: parameter CHAIN_MASK (NCELL bits, default 1) is added.
  - When CTR_OVF fires on a plus cycle of cell i, with i < NCELL-1 and CHAIN_MASK[i]=1, a PINC is posted to cell i+1 in the same CLOCK.
  - The chained request is merged with external requests under the same cancel rules.
- Without the macro: overflow is only reported on CTR_OVF; no chaining logic or parameter exists.

Decomposition:
- Package ctr_sched_pkg holds:
  - state enum {ST_INST, ST_CTR};
  - TP bit-index constants TP_T07 = 6 and TP_T12 = 11;
  - a direction typedef (DIR_PLUS / DIR_MINUS).
- Sub-module ctr_priority_enc is a parameterised NCELL-wide lowest-index-first encoder. It outputs a valid flag and an index.

Test Plan:
- PINC_REQ[5] pulse, then T01..T12 sequence → next MCT: CTR_CYCLE=1, CTR_IDX=5, CTR_DIR=0; pp[5] cleared at its end; CTR_PEND=0.
- MINC_REQ[3] and PINC_REQ[7] in the same CLOCK → two consecutive counter cycles: first idx 3 with DIR=1, then idx 7 with DIR=0; no instruction cycle between them.
- PINC_REQ[2], then MINC_REQ[2] before T12 → no counter cycle; CTR_PEND=0.
- Requests on cells 0–4 with MAX_BURST=3 → counter cycles for cells 0, 1, 2; then one INST with BURST_YIELD=1; then cells 3 and 4.
- Counter cycle on cell 0 with DIR=0 and OVF=1 during T07 → CTR_OVF is a one-CLOCK pulse. With CTR_OVF_CHAIN_EN, the next MCT serves cell 1 with a plus cycle.
- GOJAM during a CTR cycle at T04 with pending cells 1 and 9 → CTR_CYCLE=0 on the next CLOCK; CTR_PEND=0; STOP=1 afterwards with PINC_REQ[4] → no cycle until STOP=0.
